// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle ops complete in one cycle; MOD runs one
// restoring-division bit per cycle. Results are held until the consumer takes them.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; in_ready=1
// DIV    | iterative restoring division in progress (MOD only)
// DONE   | result/flags valid and held until out_ready
module alu_seq #(
  parameter int W      = 8,
  parameter bit MOD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         zero,
  output logic         err
);

  localparam int SW = $clog2(W);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SLL  = 5'b00010;
  localparam logic [4:0] OP_SRL  = 5'b00011;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SUBU = 5'b01000;
  localparam logic [4:0] OP_ADDU = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_SEZ  = 5'b01011;
  localparam logic [4:0] OP_SEQ  = 5'b01100;
  localparam logic [4:0] OP_MOD  = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [W:0]    sum_imm;
  logic [SW-1:0] shamt;
  logic [W-1:0]  alu_res;
  logic          alu_ovf;
  logic          alu_err;
  logic          is_mod;
  logic [W:0]    div_shift;
  logic [W:0]    div_trial;
  logic [W-1:0]  rem_nxt;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign sum_imm = {1'b0, a} + {{(W-1){1'b0}}, op[1:0]};
  assign shamt   = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    is_mod  = 1'b0;
    casez (op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_ADDU: begin
        alu_res = sum[W-1:0];
        alu_ovf = sum[W];
      end
      OP_SUBU: begin
        alu_res = diff[W-1:0];
        alu_ovf = diff[W];
      end
      5'b100??: begin
        alu_res = sum_imm[W-1:0];
        alu_ovf = sum_imm[W];
      end
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SEQ:  alu_res = {{(W-1){1'b0}}, (a == b)};
      OP_SEZ:  alu_res = {{(W-1){1'b0}}, (a == '0)};
      OP_AND:  alu_res = a & b;
      OP_MOD: begin
        if (MOD_EN) is_mod  = 1'b1;
        else        alu_err = 1'b1;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One restoring step; with a zero divisor the trial never goes negative,
  // so the remainder simply accumulates the dividend and ends equal to a.
  assign div_shift = {rem_q, dvd_q[W-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};
  assign rem_nxt   = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mod) begin
            state_d = S_DIV;
            rem_d   = '0;
            dvd_d   = a;
            dvs_d   = b;
            cnt_d   = SW'(W-1);
            ovf_d   = 1'b0;
            err_d   = (b == '0);
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            ovf_d    = alu_ovf;
            err_d    = alu_err;
            zero_d   = (alu_res == '0);
          end
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        dvd_d = {dvd_q[W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = rem_nxt;
          zero_d   = (rem_nxt == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): a vector table for every opcode plus
// hand-written sequences for backpressure and mid-operation reset.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       ovf;
  logic       zero;
  logic       err;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.W(8), .MOD_EN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    logic       zero;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [4:0] o,
                              input logic [7:0] aa, input logic [7:0] bb,
                              input logic [7:0] r, input logic v,
                              input logic z, input logic e, input int l);
    vec_t t;
    t.name = n; t.op = o; t.a = aa; t.b = bb; t.res = r;
    t.ovf = v; t.zero = z; t.err = e; t.lat = l;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op = 5'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk({v.name, "_busy"}, 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
    chk({v.name, "_res"}, 32'(result), 32'(v.res));
    chk({v.name, "_flags"}, {29'd0, ovf, zero, err}, {29'd0, v.ovf, v.zero, v.err});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen_valid;
    vecs.push_back(mk("add_ovf",   5'b00000, 8'd100, 8'd50,  8'h96, 1, 0, 0, 1));
    vecs.push_back(mk("subu_brw",  5'b01000, 8'd3,   8'd5,   8'hFE, 1, 0, 0, 1));
    vecs.push_back(mk("subu_ok",   5'b01000, 8'd5,   8'd3,   8'h02, 0, 0, 0, 1));
    vecs.push_back(mk("sub_ovf",   5'b00001, 8'h80,  8'h01,  8'h7F, 1, 0, 0, 1));
    vecs.push_back(mk("addu_cy",   5'b01001, 8'hFF,  8'h01,  8'h00, 1, 1, 0, 1));
    vecs.push_back(mk("add_pos",   5'b00000, 8'h7F,  8'h01,  8'h80, 1, 0, 0, 1));
    vecs.push_back(mk("add_nov",   5'b00000, 8'hFF,  8'h01,  8'h00, 0, 1, 0, 1));
    vecs.push_back(mk("sll",       5'b00010, 8'h01,  8'h0B,  8'h08, 0, 0, 0, 1));
    vecs.push_back(mk("srl",       5'b00011, 8'h80,  8'h0F,  8'h01, 0, 0, 0, 1));
    vecs.push_back(mk("slt_t",     5'b00111, 8'h80,  8'h01,  8'h01, 0, 0, 0, 1));
    vecs.push_back(mk("slt_f",     5'b00111, 8'h01,  8'h80,  8'h00, 0, 1, 0, 1));
    vecs.push_back(mk("seq",       5'b01100, 8'h5A,  8'h5A,  8'h01, 0, 0, 0, 1));
    vecs.push_back(mk("sez_t",     5'b01011, 8'h00,  8'h33,  8'h01, 0, 0, 0, 1));
    vecs.push_back(mk("sez_f",     5'b01011, 8'h01,  8'h00,  8'h00, 0, 1, 0, 1));
    vecs.push_back(mk("and",       5'b01010, 8'hF0,  8'h3C,  8'h30, 0, 0, 0, 1));
    vecs.push_back(mk("addi3",     5'b10011, 8'hFF,  8'h55,  8'h02, 1, 0, 0, 1));
    vecs.push_back(mk("addi1",     5'b10001, 8'h10,  8'hAA,  8'h11, 0, 0, 0, 1));
    vecs.push_back(mk("ill_04",    5'b00100, 8'h12,  8'h34,  8'h00, 0, 1, 1, 1));
    vecs.push_back(mk("ill_1f",    5'b11111, 8'hFF,  8'hFF,  8'h00, 0, 1, 1, 1));
    vecs.push_back(mk("mod",       5'b01111, 8'd200, 8'd7,   8'd4,  0, 0, 0, 9));
    vecs.push_back(mk("mod_div0",  5'b01111, 8'd9,   8'd0,   8'd9,  0, 0, 1, 9));
    vecs.push_back(mk("mod_exact", 5'b01111, 8'd14,  8'd7,   8'd0,  0, 1, 0, 9));
    vecs.push_back(mk("mod_small", 5'b01111, 8'd5,   8'd200, 8'd5,  0, 0, 0, 9));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    step();
    step();
    chk("reset_state", {26'd0, in_ready, out_valid, ovf, zero, err, 1'b0},
        {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Backpressure: result held, new requests ignored
    op = 5'b00000; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    step();
    a = 8'd7; b = 8'd9; op = 5'b01001;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {30'd0, out_valid, in_ready}, 32'b10);
      chk("hold_res", 32'(result), 32'd2);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release", {30'd0, out_valid, in_ready}, 32'b01);

    // Reset three cycles into a MOD
    op = 5'b01111; a = 8'd200; b = 8'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_state", {27'd0, in_ready, out_valid, ovf, zero, err},
        {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("abort_cnt", 32'(dut.cnt_q), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    run_vec(mk("post_rst_addi", 5'b10011, 8'hFF, 8'h00, 8'h02, 1, 0, 0, 1));
    run_vec(mk("post_rst_mod", 5'b01111, 8'd200, 8'd7, 8'd4, 0, 0, 0, 9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
